// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the Mini-SRC datapath.
// Each instruction is fetched in T0..T2 and executed in T3..T7, with the opcode taken from IR[31:27].
// States that assert Read are held for MEM_WAIT extra cycles so that slow RAM can respond.
// IR is a datapath register loaded only in T2, so the execute-step decode changes only on clock edges.
module control_unit #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        CON,
   input  logic        stop,
   output logic        Run,
   output logic        PCout,
   output logic        MDRout,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIout,
   output logic        LOout,
   output logic        InPortout,
   output logic        Cout,
   output logic        BAout,
   output logic        PCin,
   output logic        IRin,
   output logic        MARin,
   output logic        MDRin,
   output logic        Yin,
   output logic        Zlowin,
   output logic        Zhighin,
   output logic        HIin,
   output logic        LOin,
   output logic        CONin,
   output logic        OutPortin,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSED, S_HALTED
   } state_t;

   localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

   state_t     state;
   logic [2:0] wait_cnt;
   logic       con_q;

   logic [4:0] op;
   logic is_ld, is_ldi, is_st, is_alu, is_imm, is_muldiv, is_negnot;
   logic is_br, is_jr, is_jal, is_in, is_out, is_mfhi, is_mflo, is_halt;
   logic [2:0] last_step;
   state_t     boundary_next;

   assign op        = IR[31:27];
   assign is_ld     = (op == 5'd0);
   assign is_ldi    = (op == 5'd1);
   assign is_st     = (op == 5'd2);
   assign is_alu    = (op >= 5'd3) && (op <= 5'd14);
   assign is_imm    = (op >= 5'd12) && (op <= 5'd14);
   assign is_muldiv = (op == 5'd15) || (op == 5'd16);
   assign is_negnot = (op == 5'd17) || (op == 5'd18);
   assign is_br     = (op == 5'd19);
   assign is_jr     = (op == 5'd20);
   assign is_jal    = (op == 5'd21);
   assign is_in     = (op == 5'd22);
   assign is_out    = (op == 5'd23);
   assign is_mfhi   = (op == 5'd24);
   assign is_mflo   = (op == 5'd25);
   assign is_halt   = (op == 5'd27);

   // Where stepping stops for the current opcode, and where an instruction boundary leads.
   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      last_step = 3'd3;
      if (is_ld || is_st)                  last_step = 3'd7;
      else if (is_muldiv || is_br)         last_step = 3'd6;
      else if (is_alu || is_ldi)           last_step = 3'd5;
      else if (is_negnot || is_jal)        last_step = 3'd4;
      boundary_next = stop ? S_PAUSED : S_T0;
   end

   // Sequencer: state, memory-wait counter and the branch condition sampled leaving br T5.
   // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state    <= S_RESET;
         wait_cnt <= '0;
         con_q    <= 1'b0;
      end else begin
         case (state)
            S_RESET: state <= S_T0;
            S_T0: begin
               state    <= S_T1;
               wait_cnt <= WAIT_INIT;
            end
            S_T1: begin
               if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
               else                  state    <= S_T2;
            end
            S_T2: state <= S_T3;
            S_T3: begin
               if (is_halt)                 state <= S_HALTED;
               else if (last_step == 3'd3)  state <= boundary_next;
               else                         state <= S_T4;
            end
            S_T4: state <= (last_step == 3'd4) ? boundary_next : S_T5;
            S_T5: begin
               con_q <= CON;
               if (last_step == 3'd5) state <= boundary_next;
               else begin
                  state    <= S_T6;
                  wait_cnt <= WAIT_INIT;
               end
            end
            S_T6: begin
               if (is_ld && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
               else if (last_step == 3'd6)    state    <= boundary_next;
               else                           state    <= S_T7;
            end
            S_T7:     state <= boundary_next;
            S_PAUSED: if (!stop) state <= S_T0;
            S_HALTED: state <= S_HALTED;
            default:  state <= S_RESET;
         endcase
      end
   end

   // Strobe decode from the registered state (and the IR register for execute steps).
   always_comb begin
      {PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Cout, BAout} = '0;
      {PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, HIin, LOin, CONin, OutPortin} = '0;
      {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout} = '0;
      Run = (state >= S_T0) && (state <= S_T7);
      case (state)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
         S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: begin
            if (is_alu)                         begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            else if (is_muldiv)                 begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            else if (is_negnot)                 begin Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; end
            else if (is_ld || is_ldi || is_st)  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            else if (is_br)                     begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            else if (is_jr)                     begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            else if (is_jal)                    begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
            else if (is_in)                     begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (is_out)                    begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
            else if (is_mfhi)                   begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (is_mflo)                   begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
         end
         S_T4: begin
            if (is_alu && is_imm)               begin Cout = 1'b1; Zlowin = 1'b1; end
            else if (is_alu)                    begin Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; end
            else if (is_muldiv)                 begin Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; Zhighin = 1'b1; end
            else if (is_negnot)                 begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (is_ld || is_ldi || is_st)  begin Cout = 1'b1; Zlowin = 1'b1; end
            else if (is_br)                     begin PCout = 1'b1; Yin = 1'b1; end
            else if (is_jal)                    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
         end
         S_T5: begin
            if (is_alu || is_ldi)               begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (is_muldiv)                 begin Zlowout = 1'b1; LOin = 1'b1; end
            else if (is_ld || is_st)            begin Zlowout = 1'b1; MARin = 1'b1; end
            else if (is_br)                     begin Cout = 1'b1; Zlowin = 1'b1; end
         end
         S_T6: begin
            if (is_muldiv)                      begin Zhighout = 1'b1; HIin = 1'b1; end
            else if (is_ld)                     begin Read = 1'b1; MDRin = 1'b1; end
            else if (is_st)                     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            else if (is_br && con_q)            begin Zlowout = 1'b1; PCin = 1'b1; end
         end
         S_T7: begin
            if (is_ld)                          begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (is_st)                     Write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-opcode vector table, an instruction-level
// reference model driven by random opcodes, and hand sequences for reset, wait, stop and halt.
module tb_control_unit;

   typedef logic [28:0] vec_t;

   localparam vec_t M_PCOUT     = vec_t'(1) << 0;
   localparam vec_t M_MDROUT    = vec_t'(1) << 1;
   localparam vec_t M_ZLOWOUT   = vec_t'(1) << 2;
   localparam vec_t M_ZHIGHOUT  = vec_t'(1) << 3;
   localparam vec_t M_HIOUT     = vec_t'(1) << 4;
   localparam vec_t M_LOOUT     = vec_t'(1) << 5;
   localparam vec_t M_INPORTOUT = vec_t'(1) << 6;
   localparam vec_t M_COUT      = vec_t'(1) << 7;
   localparam vec_t M_BAOUT     = vec_t'(1) << 8;
   localparam vec_t M_PCIN      = vec_t'(1) << 9;
   localparam vec_t M_IRIN      = vec_t'(1) << 10;
   localparam vec_t M_MARIN     = vec_t'(1) << 11;
   localparam vec_t M_MDRIN     = vec_t'(1) << 12;
   localparam vec_t M_YIN       = vec_t'(1) << 13;
   localparam vec_t M_ZLOWIN    = vec_t'(1) << 14;
   localparam vec_t M_ZHIGHIN   = vec_t'(1) << 15;
   localparam vec_t M_HIIN      = vec_t'(1) << 16;
   localparam vec_t M_LOIN      = vec_t'(1) << 17;
   localparam vec_t M_CONIN     = vec_t'(1) << 18;
   localparam vec_t M_OUTPORTIN = vec_t'(1) << 19;
   localparam vec_t M_INCPC     = vec_t'(1) << 20;
   localparam vec_t M_READ      = vec_t'(1) << 21;
   localparam vec_t M_WRITE     = vec_t'(1) << 22;
   localparam vec_t M_GRA       = vec_t'(1) << 23;
   localparam vec_t M_GRB       = vec_t'(1) << 24;
   localparam vec_t M_GRC       = vec_t'(1) << 25;
   localparam vec_t M_RIN       = vec_t'(1) << 26;
   localparam vec_t M_ROUT      = vec_t'(1) << 27;
   localparam vec_t M_RUN       = vec_t'(1) << 28;

   localparam vec_t V_T0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] ir    = '0;
   logic        con   = 1'b0;
   logic        stop  = 1'b0;
   wire  [28:0] o0;
   wire  [28:0] o2;

   int checks = 0;
   int errors = 0;
   vec_t exp_q[$];
   bit   wr_watch = 1'b0;
   bit   wr_seen  = 1'b0;

   always #5 clock = ~clock;

   control_unit #(.MEM_WAIT(0)) u_dut0 (
      .clock(clock), .clear(clear), .IR(ir), .CON(con), .stop(stop), .Run(o0[28]),
      .PCout(o0[0]), .MDRout(o0[1]), .Zlowout(o0[2]), .Zhighout(o0[3]), .HIout(o0[4]),
      .LOout(o0[5]), .InPortout(o0[6]), .Cout(o0[7]), .BAout(o0[8]), .PCin(o0[9]),
      .IRin(o0[10]), .MARin(o0[11]), .MDRin(o0[12]), .Yin(o0[13]), .Zlowin(o0[14]),
      .Zhighin(o0[15]), .HIin(o0[16]), .LOin(o0[17]), .CONin(o0[18]), .OutPortin(o0[19]),
      .IncPC(o0[20]), .Read(o0[21]), .Write(o0[22]), .Gra(o0[23]), .Grb(o0[24]),
      .Grc(o0[25]), .Rin(o0[26]), .Rout(o0[27])
   );

   control_unit #(.MEM_WAIT(2)) u_dut2 (
      .clock(clock), .clear(clear), .IR(ir), .CON(con), .stop(stop), .Run(o2[28]),
      .PCout(o2[0]), .MDRout(o2[1]), .Zlowout(o2[2]), .Zhighout(o2[3]), .HIout(o2[4]),
      .LOout(o2[5]), .InPortout(o2[6]), .Cout(o2[7]), .BAout(o2[8]), .PCin(o2[9]),
      .IRin(o2[10]), .MARin(o2[11]), .MDRin(o2[12]), .Yin(o2[13]), .Zlowin(o2[14]),
      .Zhighin(o2[15]), .HIin(o2[16]), .LOin(o2[17]), .CONin(o2[18]), .OutPortin(o2[19]),
      .IncPC(o2[20]), .Read(o2[21]), .Write(o2[22]), .Gra(o2[23]), .Grb(o2[24]),
      .Grc(o2[25]), .Rin(o2[26]), .Rout(o2[27])
   );

   // Any Write pulse while watching is recorded, even one shorter than a clock period.
   always @(o0) if (wr_watch && ((o0 & M_WRITE) != '0)) wr_seen = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: the whole cycle-by-cycle strobe list of one instruction, from the opcode rules.
   task automatic build_exp(input logic [4:0] op, input logic c, input int mw);
      exp_q.delete();
      exp_q.push_back(V_T0);
      for (int i = 0; i <= mw; i++) exp_q.push_back(M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN);
      exp_q.push_back(M_RUN | M_MDROUT | M_IRIN);
      if (op >= 3 && op <= 14) begin
         exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
         if (op >= 12) exp_q.push_back(M_RUN | M_COUT | M_ZLOWIN);
         else          exp_q.push_back(M_RUN | M_GRC | M_ROUT | M_ZLOWIN);
         exp_q.push_back(M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
      end else if (op == 15 || op == 16) begin
         exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_YIN);
         exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_ZLOWIN | M_ZHIGHIN);
         exp_q.push_back(M_RUN | M_ZLOWOUT | M_LOIN);
         exp_q.push_back(M_RUN | M_ZHIGHOUT | M_HIIN);
      end else if (op == 17 || op == 18) begin
         exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_ZLOWIN);
         exp_q.push_back(M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
      end else if (op <= 2) begin
         exp_q.push_back(M_RUN | M_GRB | M_BAOUT | M_YIN);
         exp_q.push_back(M_RUN | M_COUT | M_ZLOWIN);
         if (op == 1) exp_q.push_back(M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
         else begin
            exp_q.push_back(M_RUN | M_ZLOWOUT | M_MARIN);
            if (op == 0) begin
               for (int i = 0; i <= mw; i++) exp_q.push_back(M_RUN | M_READ | M_MDRIN);
               exp_q.push_back(M_RUN | M_MDROUT | M_GRA | M_RIN);
            end else begin
               exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_MDRIN);
               exp_q.push_back(M_RUN | M_WRITE);
            end
         end
      end else if (op == 19) begin
         exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_CONIN);
         exp_q.push_back(M_RUN | M_PCOUT | M_YIN);
         exp_q.push_back(M_RUN | M_COUT | M_ZLOWIN);
         exp_q.push_back(c ? (M_RUN | M_ZLOWOUT | M_PCIN) : M_RUN);
      end else if (op == 20) exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_PCIN);
      else if (op == 21) begin
         exp_q.push_back(M_RUN | M_PCOUT | M_GRB | M_RIN);
         exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_PCIN);
      end
      else if (op == 22) exp_q.push_back(M_RUN | M_INPORTOUT | M_GRA | M_RIN);
      else if (op == 23) exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_OUTPORTIN);
      else if (op == 24) exp_q.push_back(M_RUN | M_HIOUT | M_GRA | M_RIN);
      else if (op == 25) exp_q.push_back(M_RUN | M_LOOUT | M_GRA | M_RIN);
      else exp_q.push_back(M_RUN);  // nop, halt and unused opcodes: one empty T3
   endtask

   // Starts just after the edge that entered T0; ends just after the edge that leaves the instruction.
   task automatic run_instr(input string name, input logic [4:0] op, input logic c,
                            input int which, input int stop_at);
      build_exp(op, c, (which == 2) ? 2 : 0);
      ir  = {op, 27'($urandom)};
      con = c;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i == stop_at) stop = 1'b1;
         @(negedge clock);
         check($sformatf("%s op%0d step%0d", name, op, i), 32'((which == 2) ? o2 : o0), 32'(exp_q[i]));
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      clear = 1'b0;
      stop  = 1'b0;
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic [31:0] ir;
      logic        con;
      int          exp_len;
      vec_t        exp_t3;
   } rec_t;

   rec_t tbl[17];

   initial begin
      int   cnt;
      vec_t t3;

      tbl[0]  = '{32'h1891_8000, 1'b0, 6, M_RUN | M_GRB | M_ROUT | M_YIN};        // add R1,R2,R3
      tbl[1]  = '{{5'd12, 27'h0}, 1'b0, 6, M_RUN | M_GRB | M_ROUT | M_YIN};       // immediate ALU
      tbl[2]  = '{{5'd15, 27'h0}, 1'b0, 7, M_RUN | M_GRA | M_ROUT | M_YIN};       // mul
      tbl[3]  = '{{5'd17, 27'h0}, 1'b0, 5, M_RUN | M_GRB | M_ROUT | M_ZLOWIN};    // neg
      tbl[4]  = '{{5'd0,  27'h0}, 1'b0, 8, M_RUN | M_GRB | M_BAOUT | M_YIN};      // ld
      tbl[5]  = '{{5'd1,  27'h0}, 1'b0, 6, M_RUN | M_GRB | M_BAOUT | M_YIN};      // ldi
      tbl[6]  = '{{5'd2,  27'h0}, 1'b0, 8, M_RUN | M_GRB | M_BAOUT | M_YIN};      // st
      tbl[7]  = '{{5'd19, 27'h0}, 1'b0, 7, M_RUN | M_GRA | M_ROUT | M_CONIN};     // br not taken
      tbl[8]  = '{{5'd19, 27'h0}, 1'b1, 7, M_RUN | M_GRA | M_ROUT | M_CONIN};     // br taken
      tbl[9]  = '{{5'd20, 27'h0}, 1'b0, 4, M_RUN | M_GRA | M_ROUT | M_PCIN};      // jr
      tbl[10] = '{{5'd21, 27'h0}, 1'b0, 5, M_RUN | M_PCOUT | M_GRB | M_RIN};      // jal
      tbl[11] = '{{5'd22, 27'h0}, 1'b0, 4, M_RUN | M_INPORTOUT | M_GRA | M_RIN};  // in
      tbl[12] = '{{5'd23, 27'h0}, 1'b0, 4, M_RUN | M_GRA | M_ROUT | M_OUTPORTIN}; // out
      tbl[13] = '{{5'd24, 27'h0}, 1'b0, 4, M_RUN | M_HIOUT | M_GRA | M_RIN};      // mfhi
      tbl[14] = '{{5'd25, 27'h0}, 1'b0, 4, M_RUN | M_LOOUT | M_GRA | M_RIN};      // mflo
      tbl[15] = '{{5'd26, 27'h0}, 1'b0, 4, M_RUN};                                // nop
      tbl[16] = '{{5'd30, 27'h0}, 1'b0, 4, M_RUN};                                // unused opcode

      // Held in reset: everything quiet on both instances.
      repeat (2) @(negedge clock);
      check("reset dut0", 32'(o0), 32'h0);
      check("reset dut2", 32'(o2), 32'h0);

      // Vector table: instruction length (T0 to next T0) and the T3 strobe set.
      do_reset();
      @(negedge clock);
      check("T0 after release", 32'(o0), 32'(V_T0));
      foreach (tbl[k]) begin
         ir  = tbl[k].ir;
         con = tbl[k].con;
         cnt = 0;
         t3  = '0;
         do begin
            @(posedge clock);
            @(negedge clock);
            cnt++;
            if (cnt == 3) t3 = o0;
         end while (o0 != V_T0 && cnt < 30);
         check($sformatf("tbl%0d length", k), 32'(cnt), 32'(tbl[k].exp_len));
         check($sformatf("tbl%0d T3", k), 32'(t3), 32'(tbl[k].exp_t3));
      end

      // Branch not taken then taken, step by step against the model.
      do_reset();
      run_instr("br", 5'd19, 1'b0, 0, -1);
      run_instr("br", 5'd19, 1'b1, 0, -1);
      @(negedge clock);
      check("T0 after br", 32'(o0), 32'(V_T0));

      // Slow memory: ld on the MEM_WAIT=2 instance takes 12 cycles.
      do_reset();
      run_instr("ld wait2", 5'd0, 1'b0, 2, -1);
      @(negedge clock);
      check("T0 after ld wait2", 32'(o2), 32'(V_T0));

      // stop raised in mul T4: instruction completes, then PAUSED until stop drops.
      do_reset();
      run_instr("mul stop", 5'd15, 1'b0, 0, 4);
      repeat (3) begin
         @(negedge clock);
         check("paused", 32'(o0), 32'h0);
      end
      @(posedge clock);
      #1;
      stop = 1'b0;
      @(negedge clock);
      check("paused held at stop drop", 32'(o0), 32'h0);
      @(negedge clock);
      check("T0 after resume", 32'(o0), 32'(V_T0));

      // clear during st T6: strobes drop at once and Write never appears.
      do_reset();
      ir  = {5'd2, 27'h0};
      wr_seen  = 1'b0;
      wr_watch = 1'b1;
      repeat (6) @(posedge clock);
      @(negedge clock);
      check("st T6", 32'(o0), 32'(M_RUN | M_GRA | M_ROUT | M_MDRIN));
      #2 clear = 1'b0;
      #1 check("clear mid st", 32'(o0), 32'h0);
      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      check("T0 after mid clear", 32'(o0), 32'(V_T0));
      wr_watch = 1'b0;
      check("no write pulse", 32'(wr_seen), 32'h0);

      // halt: quiet for 100 cycles whatever stop does; only clear restarts.
      do_reset();
      run_instr("halt", 5'd27, 1'b0, 0, -1);
      for (int i = 0; i < 100; i++) begin
         stop = i[3];
         @(negedge clock);
         check($sformatf("halted cyc%0d", i), 32'(o0), 32'h0);
      end
      do_reset();
      @(negedge clock);
      check("T0 after halt clear", 32'(o0), 32'(V_T0));

      // Random instruction stream against the model (halt excluded so the stream keeps running).
      do_reset();
      for (int n = 0; n < 40; n++) begin
         logic [4:0] op;
         op = 5'($urandom_range(0, 31));
         if (op == 5'd27) op = 5'd26;
         run_instr("rand", op, 1'($urandom), 0, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
